// File: rtl/seq_control_unit_if.sv
// seq_control_unit_if: instruction-in / datapath-controls-out bundle for seq_control_unit.
//   master: instruction register side (drives OPCODE, INSTR_VALID, SHAMT)
//   slave : control unit side (drives all datapath/PC controls, STALL, ILLEGAL)
interface seq_control_unit_if #(
  parameter int unsigned OPCODE_W = 8,
  parameter int unsigned SHAMT_W  = 3
);
  logic [OPCODE_W-1:0] OPCODE;
  logic                INSTR_VALID;
  logic [SHAMT_W-1:0]  SHAMT;

  logic                WRITEENABLE;
  logic                ALUSRC;
  logic [2:0]          ALUOP;
  logic                NEMUX;
  logic                BRANCH;
  logic                BNE;
  logic                JUMP;
  logic [1:0]          SHIFTOP;
  logic                SHIFT_STEP;
  logic                STALL;
  logic                ILLEGAL;

  modport master (
    output OPCODE, INSTR_VALID, SHAMT,
    input  WRITEENABLE, ALUSRC, ALUOP, NEMUX, BRANCH, BNE, JUMP,
           SHIFTOP, SHIFT_STEP, STALL, ILLEGAL
  );

  modport slave (
    input  OPCODE, INSTR_VALID, SHAMT,
    output WRITEENABLE, ALUSRC, ALUOP, NEMUX, BRANCH, BNE, JUMP,
           SHIFTOP, SHIFT_STEP, STALL, ILLEGAL
  );
endinterface

// File: rtl/seq_control_unit.sv
// seq_control_unit: registered opcode decoder that sequences multi-cycle ops
// (iterative multiply, bit-serial shifts), holding controls and raising STALL
// until the last cycle, which carries the register-file write.
//   CLK, RESET_N : clock, async active-low reset
//   bus (slave)  : OPCODE/INSTR_VALID/SHAMT in; WRITEENABLE, ALUSRC, ALUOP,
//                  NEMUX, BRANCH, BNE, JUMP, SHIFTOP, SHIFT_STEP, STALL,
//                  ILLEGAL out (all registered)
// Build option: SEQ_CU_MULT_EN enables the mult opcode (0x09); without it
// 0x09 decodes as illegal and the counter is only SHAMT_W bits wide.
module seq_control_unit #(
  parameter int unsigned OPCODE_W    = 8,
  parameter int unsigned MULT_CYCLES = 3,
  parameter int unsigned SHAMT_W     = 3
) (
  input  logic             CLK,
  input  logic             RESET_N,
  seq_control_unit_if.slave bus
);

  if (MULT_CYCLES < 2 || MULT_CYCLES > 16) begin : g_bad_mult_cycles
    $error("seq_control_unit: MULT_CYCLES must be in 2..16");
  end

`ifdef SEQ_CU_MULT_EN
  localparam int unsigned SHIFT_SPAN = 1 << SHAMT_W;
  localparam int unsigned CNT_SPAN   = (MULT_CYCLES > SHIFT_SPAN) ? MULT_CYCLES : SHIFT_SPAN;
  localparam int unsigned CNT_W      = $clog2(CNT_SPAN);
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
`else
  localparam int unsigned CNT_W      = SHAMT_W;
`endif

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_AND  = 5'h02;
  localparam logic [4:0] OP_OR   = 5'h03;
  localparam logic [4:0] OP_MOV  = 5'h04;
  localparam logic [4:0] OP_LDI  = 5'h05;
  localparam logic [4:0] OP_J    = 5'h06;
  localparam logic [4:0] OP_BEQ  = 5'h07;
  localparam logic [4:0] OP_BNE  = 5'h08;
  localparam logic [4:0] OP_MULT = 5'h09;
  localparam logic [4:0] OP_SLL  = 5'h0A;
  localparam logic [4:0] OP_SRL  = 5'h0B;
  localparam logic [4:0] OP_SRA  = 5'h0C;
  localparam logic [4:0] OP_ROR  = 5'h0D;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic             alusrc_q, alusrc_d;
  logic [2:0]       aluop_q, aluop_d;
  logic             nemux_q, nemux_d;
  logic             branch_q, branch_d;
  logic             bne_q, bne_d;
  logic             jump_q, jump_d;
  logic [1:0]       shiftop_q, shiftop_d;
  logic             step_q, step_d;
  logic             stall_q, stall_d;
  logic             illegal_q, illegal_d;

  logic [4:0]       op5;
  logic             op_hi_bad;

  assign op5       = bus.OPCODE[4:0];
  assign op_hi_bad = (bus.OPCODE >> 5) != '0;

  // State, counter and output registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      alusrc_q  <= 1'b0;
      aluop_q   <= 3'b000;
      nemux_q   <= 1'b0;
      branch_q  <= 1'b0;
      bne_q     <= 1'b0;
      jump_q    <= 1'b0;
      shiftop_q <= 2'b00;
      step_q    <= 1'b0;
      stall_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      alusrc_q  <= alusrc_d;
      aluop_q   <= aluop_d;
      nemux_q   <= nemux_d;
      branch_q  <= branch_d;
      bne_q     <= bne_d;
      jump_q    <= jump_d;
      shiftop_q <= shiftop_d;
      step_q    <= step_d;
      stall_q   <= stall_d;
      illegal_q <= illegal_d;
    end
  end

  // Decode in IDLE; in BUSY hold the datapath controls and count down
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = 1'b0;
    alusrc_d  = 1'b0;
    aluop_d   = 3'b000;
    nemux_d   = 1'b0;
    branch_d  = 1'b0;
    bne_d     = 1'b0;
    jump_d    = 1'b0;
    shiftop_d = 2'b00;
    step_d    = 1'b0;
    stall_d   = 1'b0;
    illegal_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.INSTR_VALID) begin
          if (op_hi_bad) begin
            illegal_d = 1'b1;
          end else begin
            case (op5)
              OP_ADD: begin we_d = 1'b1; aluop_d = 3'b001; alusrc_d = 1'b1; end
              OP_SUB: begin we_d = 1'b1; aluop_d = 3'b001; alusrc_d = 1'b1; nemux_d = 1'b1; end
              OP_AND: begin we_d = 1'b1; aluop_d = 3'b010; alusrc_d = 1'b1; end
              OP_OR:  begin we_d = 1'b1; aluop_d = 3'b011; alusrc_d = 1'b1; end
              OP_MOV: begin we_d = 1'b1; aluop_d = 3'b000; alusrc_d = 1'b1; end
              OP_LDI: begin we_d = 1'b1; end
              OP_J:   begin jump_d = 1'b1; end
              OP_BEQ: begin aluop_d = 3'b001; alusrc_d = 1'b1; nemux_d = 1'b1; branch_d = 1'b1; end
              OP_BNE: begin aluop_d = 3'b001; alusrc_d = 1'b1; nemux_d = 1'b1; bne_d = 1'b1; end
              OP_MULT: begin
`ifdef SEQ_CU_MULT_EN
                aluop_d = 3'b100;
                stall_d = 1'b1;
                cnt_d   = MULT_LAST;
                state_d = BUSY;
`else
                illegal_d = 1'b1;
`endif
              end
              OP_SLL, OP_SRL, OP_SRA, OP_ROR: begin
                aluop_d   = 3'b101;
                alusrc_d  = 1'b1;
                shiftop_d = 2'(op5 - OP_SLL);
                // Zero and one-bit shifts complete in a single cycle
                if (bus.SHAMT == '0) begin
                  we_d = 1'b1;
                end else if (bus.SHAMT == SHAMT_W'(1)) begin
                  we_d   = 1'b1;
                  step_d = 1'b1;
                end else begin
                  step_d  = 1'b1;
                  stall_d = 1'b1;
                  cnt_d   = CNT_W'(bus.SHAMT) - CNT_W'(1);
                  state_d = BUSY;
                end
              end
              default: illegal_d = 1'b1;
            endcase
          end
        end
      end

      BUSY: begin
        alusrc_d  = alusrc_q;
        aluop_d   = aluop_q;
        shiftop_d = shiftop_q;
        step_d    = step_q;
        cnt_d     = cnt_q - CNT_W'(1);
        // cnt_q == 1 means the coming cycle is the last one: write, release stall
        if (cnt_q == CNT_W'(1)) begin
          we_d    = 1'b1;
          state_d = IDLE;
        end else begin
          stall_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.WRITEENABLE = we_q;
  assign bus.ALUSRC      = alusrc_q;
  assign bus.ALUOP       = aluop_q;
  assign bus.NEMUX       = nemux_q;
  assign bus.BRANCH      = branch_q;
  assign bus.BNE         = bne_q;
  assign bus.JUMP        = jump_q;
  assign bus.SHIFTOP     = shiftop_q;
  assign bus.SHIFT_STEP  = step_q;
  assign bus.STALL       = stall_q;
  assign bus.ILLEGAL     = illegal_q;

endmodule

// File: tb/tb_seq_control_unit.sv
// tb_seq_control_unit: directed checks of seq_control_unit decode, multi-cycle
// sequencing, back-to-back issue and asynchronous reset.
module tb_seq_control_unit;

  localparam int unsigned OPCODE_W    = 8;
  localparam int unsigned MULT_CYCLES = 3;
  localparam int unsigned SHAMT_W     = 3;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  seq_control_unit_if #(.OPCODE_W(OPCODE_W), .SHAMT_W(SHAMT_W)) bus ();

  seq_control_unit #(
    .OPCODE_W   (OPCODE_W),
    .MULT_CYCLES(MULT_CYCLES),
    .SHAMT_W    (SHAMT_W)
  ) dut (
    .CLK    (clk),
    .RESET_N(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {WE, ALUSRC, ALUOP[2:0], NEMUX, BRANCH, BNE, JUMP, SHIFTOP[1:0], SHIFT_STEP, STALL, ILLEGAL}
  function automatic logic [13:0] ctl_now();
    return {bus.WRITEENABLE, bus.ALUSRC, bus.ALUOP, bus.NEMUX, bus.BRANCH,
            bus.BNE, bus.JUMP, bus.SHIFTOP, bus.SHIFT_STEP, bus.STALL, bus.ILLEGAL};
  endfunction

  function automatic logic [13:0] mk(input logic we, input logic alusrc,
                                     input logic [2:0] aluop, input logic nemux,
                                     input logic br, input logic bne, input logic jmp,
                                     input logic [1:0] sop, input logic step,
                                     input logic stall, input logic ill);
    return {we, alusrc, aluop, nemux, br, bne, jmp, sop, step, stall, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic valid, input logic [2:0] shamt);
    bus.OPCODE      = op;
    bus.INSTR_VALID = valid;
    bus.SHAMT       = shamt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [13:0] exp_tab [0:13];
  logic [7:0]  op_v;
  int          steps;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    drive(8'h00, 1'b0, 3'd0);

    // Single-cycle expectations; shifts use SHAMT=1
    exp_tab[0]  = mk(1, 1, 3'b001, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    exp_tab[1]  = mk(1, 1, 3'b001, 1, 0, 0, 0, 2'b00, 0, 0, 0);
    exp_tab[2]  = mk(1, 1, 3'b010, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    exp_tab[3]  = mk(1, 1, 3'b011, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    exp_tab[4]  = mk(1, 1, 3'b000, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    exp_tab[5]  = mk(1, 0, 3'b000, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    exp_tab[6]  = mk(0, 0, 3'b000, 0, 0, 0, 1, 2'b00, 0, 0, 0);
    exp_tab[7]  = mk(0, 1, 3'b001, 1, 1, 0, 0, 2'b00, 0, 0, 0);
    exp_tab[8]  = mk(0, 1, 3'b001, 1, 0, 1, 0, 2'b00, 0, 0, 0);
    exp_tab[9]  = mk(0, 0, 3'b000, 0, 0, 0, 0, 2'b00, 0, 0, 1);
    exp_tab[10] = mk(1, 1, 3'b101, 0, 0, 0, 0, 2'b00, 1, 0, 0);
    exp_tab[11] = mk(1, 1, 3'b101, 0, 0, 0, 0, 2'b01, 1, 0, 0);
    exp_tab[12] = mk(1, 1, 3'b101, 0, 0, 0, 0, 2'b10, 1, 0, 0);
    exp_tab[13] = mk(1, 1, 3'b101, 0, 0, 0, 0, 2'b11, 1, 0, 0);

    // Reset state
    #3;
    check("reset_state", 32'(ctl_now()), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // First add after reset
    drive(8'h00, 1'b1, 3'd0);
    tick();
    check("add_after_reset", 32'(ctl_now()), 32'(exp_tab[0]));

    // Asynchronous reset mid-cycle, no clock edge in between
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'(ctl_now()), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'h00, 1'b0, 3'd0);
    tick();
    check("nop_idle", 32'(ctl_now()), 32'h0);

    // ISA sweep (0x09 handled below)
    for (int i = 0; i < 14; i++) begin
      if (i != 9) begin
        op_v = 8'(i);
        drive(op_v, 1'b1, 3'd1);
        tick();
        check($sformatf("sweep_op%02h", i), 32'(ctl_now()), 32'(exp_tab[i]));
      end
    end

    // Illegal opcodes last one cycle
    drive(8'h0E, 1'b1, 3'd0);
    tick();
    check("illegal_0e", 32'(ctl_now()), 32'(exp_tab[9]));
    drive(8'h80, 1'b1, 3'd0);
    tick();
    check("illegal_80", 32'(ctl_now()), 32'(exp_tab[9]));
    drive(8'h00, 1'b0, 3'd0);
    tick();
    check("illegal_clears", 32'(ctl_now()), 32'h0);

`ifdef SEQ_CU_MULT_EN
    // mult then sub back-to-back
    drive(8'h09, 1'b1, 3'd0);
    tick();
    check("mult_c1", 32'(ctl_now()), 32'(mk(0, 0, 3'b100, 0, 0, 0, 0, 2'b00, 0, 1, 0)));
    drive(8'h09, 1'b0, 3'd4);
    tick();
    check("mult_c2", 32'(ctl_now()), 32'(mk(0, 0, 3'b100, 0, 0, 0, 0, 2'b00, 0, 1, 0)));
    tick();
    check("mult_c3", 32'(ctl_now()), 32'(mk(1, 0, 3'b100, 0, 0, 0, 0, 2'b00, 0, 0, 0)));
    drive(8'h01, 1'b1, 3'd0);
    tick();
    check("sub_after_mult", 32'(ctl_now()), 32'(exp_tab[1]));
`else
    drive(8'h09, 1'b1, 3'd0);
    tick();
    check("mult_disabled_illegal", 32'(ctl_now()), 32'(exp_tab[9]));
`endif

    // sra SHAMT=5: 4 stalled steps then the writing step
    drive(8'h0C, 1'b1, 3'd5);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c < 5)
        check($sformatf("sra5_c%0d", c), 32'(ctl_now()), 32'(mk(0, 1, 3'b101, 0, 0, 0, 0, 2'b10, 1, 1, 0)));
      else
        check("sra5_last", 32'(ctl_now()), 32'(mk(1, 1, 3'b101, 0, 0, 0, 0, 2'b10, 1, 0, 0)));
      if (c == 1) drive(8'h0C, 1'b0, 3'd0);
    end

    // sll SHAMT=0 issued with no bubble
    drive(8'h0A, 1'b1, 3'd0);
    tick();
    check("sll0", 32'(ctl_now()), 32'(mk(1, 1, 3'b101, 0, 0, 0, 0, 2'b00, 0, 0, 0)));

    // ror SHAMT=7: count steps until the write
    drive(8'h0D, 1'b1, 3'd7);
    steps = 0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (bus.SHIFT_STEP) steps++;
      if (c == 1) check("ror7_first", 32'(ctl_now()), 32'(mk(0, 1, 3'b101, 0, 0, 0, 0, 2'b11, 1, 1, 0)));
      if (c == 6) check("ror7_c6_we", 32'(bus.WRITEENABLE), 32'h0);
    end
    check("ror7_last", 32'(ctl_now()), 32'(mk(1, 1, 3'b101, 0, 0, 0, 0, 2'b11, 1, 0, 0)));
    check("ror7_steps", 32'(steps), 32'd7);
    drive(8'h03, 1'b1, 3'd0);
    tick();
    check("or_after_ror", 32'(ctl_now()), 32'(exp_tab[3]));

    // Reset during cycle 2 of srl SHAMT=6: no write ever
    drive(8'h0B, 1'b1, 3'd6);
    tick();
    check("srl6_c1", 32'(ctl_now()), 32'(mk(0, 1, 3'b101, 0, 0, 0, 0, 2'b01, 1, 1, 0)));
    tick();
    check("srl6_c2", 32'(ctl_now()), 32'(mk(0, 1, 3'b101, 0, 0, 0, 0, 2'b01, 1, 1, 0)));
    #2;
    rst_n = 1'b0;
    #1;
    check("srl6_reset", 32'(ctl_now()), 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("srl6_rst_we%0d", c), 32'(bus.WRITEENABLE), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'h02, 1'b1, 3'd0);
    tick();
    check("and_after_reset", 32'(ctl_now()), 32'(exp_tab[2]));
    drive(8'h00, 1'b0, 3'd0);
    tick();
    check("nop_after_and", 32'(ctl_now()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_control_unit.md
# seq_control_unit

Registered, sequencing control unit that generalises the single-cycle opcode decoder for multi-cycle operations. It decodes the 14-instruction ISA into datapath controls and holds those controls across several cycles for the iterative multiplier and the bit-serial shifter. During those cycles it asserts `STALL` to freeze PC and instruction fetch. It sits between the instruction register and the register file, ALU and PC-update logic.

## Interface
- `OPCODE_W`, default 8: opcode width. Only the low 5 bits are decoded; any nonzero upper bit makes the opcode illegal.
- `MULT_CYCLES`, default 3: multiplier latency in cycles. Legal range is 2..16.
- `SHAMT_W`, default 3: shift-amount width.

Ports (name, direction, width, meaning):
- `CLK` in 1: clock, rising edge.
- `RESET_N` in 1: reset, asynchronous, active-low.
- `OPCODE` in `OPCODE_W`: opcode from the instruction register.
- `INSTR_VALID` in 1: `OPCODE` holds a valid instruction this cycle.
- `SHAMT` in `SHAMT_W`: shift amount, taken from the immediate field.
- `WRITEENABLE` out 1: register-file write.
- `ALUSRC` out 1: 1 selects the register operand, 0 selects the immediate.
- `ALUOP` out 3: ALU function.
- `NEMUX` out 1: select the two's-complement (negated) operand.
- `BRANCH`, `BNE`, `JUMP` out 1 each: PC-update controls.
- `SHIFTOP` out 2: shift type. 00 sll, 01 srl, 10 sra, 11 ror.
- `SHIFT_STEP` out 1: ALU shifts its accumulator by one bit this cycle.
- `STALL` out 1: hold PC and instruction register.
- `ILLEGAL` out 1: the sampled opcode is undefined.

## Operation
Opcode map, with control values listed as WE/ALUOP/ALUSRC/NEMUX:
- add 0x00: 1/001/1/0.
- sub 0x01: 1/001/1/1.
- and 0x02: 1/010/1/0.
- or 0x03: 1/011/1/0.
- mov 0x04: 1/000/1/0.
- loadi 0x05: 1/000/0/0.
- j 0x06: `JUMP`=1, WE=0.
- beq 0x07: 0/001/1/1 with `BRANCH`=1.
- bne 0x08: 0/001/1/1 with `BNE`=1.
- mult 0x09: `ALUOP`=100, multi-cycle.
- sll 0x0A, srl 0x0B, sra 0x0C, ror 0x0D: `ALUOP`=101, `ALUSRC`=1, `SHIFTOP`=00, 01, 10, 11 respectively, multi-cycle.
- Any control not listed for an instruction is 0.

FSM has two states:
- IDLE:
  - At each edge, if `INSTR_VALID`=1, the opcode is decoded into the registered outputs.
  - If `INSTR_VALID`=0, all outputs go to 0 (NOP).
  - mult goes to BUSY with cnt=`MULT_CYCLES`-1.
  - A shift with `SHAMT`≥2 goes to BUSY with cnt=`SHAMT`-1.
- BUSY:
  - `OPCODE`, `INSTR_VALID` and `SHAMT` are ignored.
  - All controls and `SHIFTOP` are held.
  - cnt decrements each edge; the FSM returns to IDLE when cnt reaches 0.

Multi-cycle output rules:
- `STALL`=1 in every cycle of a multi-cycle op except the last.
- `WRITEENABLE`=1 only in the last cycle.
- Shifts: `SHIFT_STEP`=1 in each of the `SHAMT` cycles.
- `SHAMT`=0: a single cycle with WE=1, `SHIFT_STEP`=0, `STALL`=0. The ALU passes the operand through.
- `SHAMT`=1: a single cycle with `SHIFT_STEP`=1, WE=1, `STALL`=0.

Illegal opcode:
- Lasts one cycle: `ILLEGAL`=1, all other outputs 0, no write and no stall.

Counter width is clog2(max(`MULT_CYCLES`, 2^`SHAMT_W`)).

## Timing
- `RESET_N` low immediately (asynchronously) forces every output to 0, state to IDLE and cnt to 0. This includes a reset that arrives in the middle of a BUSY sequence; the aborted op never writes.
- Decode latency is one cycle: outputs for the instruction sampled at edge N are valid from edge N to edge N+1.
- mult occupies exactly `MULT_CYCLES` cycles, with `STALL` high for the first `MULT_CYCLES`-1 of them.
- A shift occupies max(`SHAMT`,1) cycles.
- Back-to-back is allowed: the edge that ends the last cycle of a multi-cycle op samples the next instruction, with no bubble.
- `STALL` is registered. Fetch holds `OPCODE` stable for the whole time `STALL`=1.

## Configuration
- `SEQ_CU_MULT_EN` defined: mult 0x09 is decoded as described above.
- `SEQ_CU_MULT_EN` undefined:
  - 0x09 is treated as illegal (`ILLEGAL`=1, no write, no stall).
  - The `MULT_CYCLES` count path is not generated.
  - Counter width becomes `SHAMT_W`.

## Test plan
- Reset:
  - Assert `RESET_N`=0 mid-cycle → all outputs 0 with no wait for a clock edge.
  - Release reset, then apply add with `INSTR_VALID`=1 → after the next edge WE=1, `ALUOP`=001, `ALUSRC`=1, `NEMUX`=0, `STALL`=0.
- Full ISA sweep: apply 0x00–0x0D, then 0x0E and 0x80.
  - 0x00–0x0D → each produces its mapped controls.
  - 0x0E and 0x80 → `ILLEGAL`=1 for one cycle, WE=0.
- mult with `MULT_CYCLES`=3, followed immediately by sub:
  - `ALUOP`=100 for 3 cycles.
  - `STALL`=1,1,0.
  - WE=0,0,1.
  - sub controls (`NEMUX`=1) appear in the very next cycle.
- sra with `SHAMT`=5:
  - `SHIFT_STEP`=1 for 5 cycles.
  - `STALL`=1 ×4, then 0.
  - WE only in cycle 5.
  - `SHIFTOP`=10 throughout.
- Shift amount corner cases:
  - sll with `SHAMT`=0 → 1 cycle, WE=1, `SHIFT_STEP`=0.
  - ror with `SHAMT`=7 → 7 steps.
- Reset mid-op:
  - `RESET_N` low during cycle 2 of `SHAMT`=6 → WE never asserts.
  - After release → IDLE, and the next instruction decodes normally.
  - With `SEQ_CU_MULT_EN` undefined, 0x09 → `ILLEGAL`=1, `STALL`=0.
